// File: rtl/icache_data_array_nway.sv
// N-way instruction-cache data array: one registered read of all ways per cycle,
// one line-refill write port driven by a critical-word-first fill FSM.
// Optional same-cycle write-to-read forwarding: define ICACHE_DA_WR_FWD_EN.
module icache_data_array_nway #(
    parameter int NUM_WAYS       = 2,
    parameter int NUM_SETS       = 64,
    parameter int WORDS_PER_LINE = 4,
    parameter int DATA_W         = 32,
    localparam int IDX_W         = $clog2(NUM_SETS),
    localparam int OFF_W         = $clog2(WORDS_PER_LINE),
    localparam int WAY_W         = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rd_en,
    input  logic [IDX_W-1:0]           rd_index,
    input  logic [OFF_W-1:0]           rd_offset,
    output logic [NUM_WAYS*DATA_W-1:0] rd_data,
    output logic                       rd_valid,
    input  logic                       fill_start,
    input  logic [IDX_W-1:0]           fill_index,
    input  logic [WAY_W-1:0]           fill_way,
    input  logic [OFF_W-1:0]           fill_offset,
    input  logic                       fill_valid,
    input  logic [DATA_W-1:0]          fill_data,
    output logic                       fill_ready,
    output logic                       fill_busy,
    output logic                       fill_done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DATA_W-1:0]          r_mem [NUM_WAYS][NUM_SETS][WORDS_PER_LINE];

    logic [IDX_W-1:0]           r_fill_idx;
    logic [WAY_W-1:0]           r_fill_way;
    logic [OFF_W-1:0]           r_ptr;
    logic [OFF_W-1:0]           r_beat_cnt;
    logic                       r_fill_done;
    logic                       r_rd_valid;
    logic [NUM_WAYS*DATA_W-1:0] r_rd_data;

    logic                       w_wr_en;
    logic                       w_last_beat;
    logic                       w_start;
    logic [NUM_WAYS*DATA_W-1:0] w_rd_word;

    // Next-state logic; reset suppresses both the write and any state advance.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_last_beat = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (fill_start && !rst) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                if (fill_valid && !rst) begin
                    w_wr_en = 1'b1;
                    if (r_beat_cnt == OFF_W'(WORDS_PER_LINE - 1)) begin
                        w_last_beat = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pointer wraps naturally because WORDS_PER_LINE is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill_idx  <= '0;
            r_fill_way  <= '0;
            r_ptr       <= '0;
            r_beat_cnt  <= '0;
            r_fill_done <= 1'b0;
        end else begin
            r_fill_done <= w_last_beat;
            if (w_start) begin
                r_fill_idx <= fill_index;
                r_fill_way <= fill_way;
                r_ptr      <= fill_offset;
                r_beat_cnt <= '0;
            end else if (w_wr_en) begin
                r_ptr      <= r_ptr + 1'b1;
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_fill_way][r_fill_idx][r_ptr] <= fill_data;
        end
    end

    always_comb begin
        w_rd_word = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            w_rd_word[w*DATA_W +: DATA_W] = r_mem[w][rd_index][rd_offset];
`ifdef ICACHE_DA_WR_FWD_EN
            // Same-location write this cycle: return the beat being written.
            if (w_wr_en && (r_fill_way == WAY_W'(w)) &&
                (r_fill_idx == rd_index) && (r_ptr == rd_offset)) begin
                w_rd_word[w*DATA_W +: DATA_W] = fill_data;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= w_rd_word;
            end
        end
    end

    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;
    assign fill_ready = (r_state == S_FILL);
    assign fill_busy  = (r_state == S_FILL);
    assign fill_done  = r_fill_done;

endmodule

// File: tb/tb_icache_data_array_nway.sv
// Bench for icache_data_array_nway: table-driven line fills, hand-written corner
// sequences and a randomized phase checked against an array-level reference model.
module tb_icache_data_array_nway;

    localparam int NW  = 2;
    localparam int NS  = 64;
    localparam int WPL = 4;
    localparam int DW  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_en;
    logic [5:0]    rd_index;
    logic [1:0]    rd_offset;
    logic [63:0]   rd_data;
    logic          rd_valid;
    logic          fill_start;
    logic [5:0]    fill_index;
    logic [0:0]    fill_way;
    logic [1:0]    fill_offset;
    logic          fill_valid;
    logic [31:0]   fill_data;
    logic          fill_ready;
    logic          fill_busy;
    logic          fill_done;

    icache_data_array_nway #(
        .NUM_WAYS(NW), .NUM_SETS(NS), .WORDS_PER_LINE(WPL), .DATA_W(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_index(rd_index), .rd_offset(rd_offset),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .fill_start(fill_start), .fill_index(fill_index), .fill_way(fill_way),
        .fill_offset(fill_offset), .fill_valid(fill_valid), .fill_data(fill_data),
        .fill_ready(fill_ready), .fill_busy(fill_busy), .fill_done(fill_done)
    );

    always #5 clk = ~clk;

    // Reference model: array contents plus a "known" flag (storage is never cleared).
    logic [31:0] m_mem [NW][NS][WPL];
    bit          m_ok  [NW][NS][WPL];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [5:0]       idx;
        logic [0:0]       way;
        logic [1:0]       off;
        logic [3:0][31:0] beat;
        logic [3:0][31:0] exp;   // expected word at line offset 0..3
    } vec_t;

    vec_t vecs [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lane(input int w);
        return rd_data[w*32 +: 32];
    endfunction

    task automatic idle_inputs();
        rd_en = 0; rd_index = 0; rd_offset = 0;
        fill_start = 0; fill_index = 0; fill_way = 0; fill_offset = 0;
        fill_valid = 0; fill_data = 0;
    endtask

    task automatic read_chk(input int idx, input int off);
        rd_en = 1; rd_index = 6'(idx); rd_offset = 2'(off);
        tick();
        rd_en = 0;
        chk("rd_valid", 32'(rd_valid), 32'd1);
        for (int w = 0; w < NW; w++)
            if (m_ok[w][idx][off]) chk($sformatf("rd s%0d o%0d w%0d", idx, off, w), lane(w), m_mem[w][idx][off]);
    endtask

    // Full refill; optional stall window before beat stall_at with a spurious fill_start.
    // With chain=1 the task returns in the fill_done cycle so the caller can start again.
    task automatic fill_line(input int idx, input int way, input int off,
                             input logic [3:0][31:0] beats,
                             input int stall_at, input int stall_n, input bit chain);
        fill_start = 1; fill_index = 6'(idx); fill_way = 1'(way); fill_offset = 2'(off);
        fill_valid = 0;
        tick();
        fill_start = 0;
        chk("busy_after_start", 32'(fill_busy), 32'd1);
        chk("ready_after_start", 32'(fill_ready), 32'd1);
        for (int k = 0; k < WPL; k++) begin
            if (k == stall_at) begin
                for (int s = 0; s < stall_n; s++) begin
                    fill_valid = 0;
                    fill_start = (s == 1);
                    fill_index = 6'(idx ^ 1); fill_way = 1'(way ^ 1); fill_offset = 2'(off + 1);
                    tick();
                    chk("busy_in_stall", 32'(fill_busy), 32'd1);
                    chk("done_in_stall", 32'(fill_done), 32'd0);
                end
                fill_start = 0;
            end
            fill_valid = 1; fill_data = beats[k];
            tick();
            m_mem[way][idx][(off + k) % WPL] = beats[k];
            m_ok[way][idx][(off + k) % WPL]  = 1;
            if (k < WPL - 1) chk("done_early", 32'(fill_done), 32'd0);
        end
        fill_valid = 0;
        chk("done_pulse", 32'(fill_done), 32'd1);
        chk("busy_after_last", 32'(fill_busy), 32'd0);
        if (!chain) begin
            tick();
            chk("done_one_cycle", 32'(fill_done), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][31:0] b;
        logic [3:0][31:0] b2;
        logic [31:0]      e_lane [NW];
        bit               e_known [NW];
        bit               a_act, e_done, wr;
        int               a_idx, a_way, a_ptr, a_cnt;

        for (int w = 0; w < NW; w++)
            for (int s = 0; s < NS; s++)
                for (int o = 0; o < WPL; o++) begin
                    m_mem[w][s][o] = '0; m_ok[w][s][o] = 0;
                end

        // Reset with every request asserted: all must be ignored.
        idle_inputs();
        rst = 1; rd_en = 1; fill_start = 1; fill_valid = 1; fill_data = 32'hDEAD_BEEF;
        tick();
        tick();
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data_lo", rd_data[31:0], 32'd0);
        chk("rst_rd_data_hi", rd_data[63:32], 32'd0);
        chk("rst_fill_ready", 32'(fill_ready), 32'd0);
        chk("rst_fill_busy", 32'(fill_busy), 32'd0);
        chk("rst_fill_done", 32'(fill_done), 32'd0);
        idle_inputs();
        rst = 0;
        tick();
        chk("post_rst_busy", 32'(fill_busy), 32'd0);

        // Table: plain and critical-word-first refills with hand-computed line images.
        vecs[0] = '{idx: 6'd5,  way: 1'd1, off: 2'd0,
                    beat: {32'hA3, 32'hA2, 32'hA1, 32'hA0}, exp: {32'hA3, 32'hA2, 32'hA1, 32'hA0}};
        vecs[1] = '{idx: 6'd63, way: 1'd0, off: 2'd2,
                    beat: {32'h44, 32'h33, 32'h22, 32'h11}, exp: {32'h22, 32'h11, 32'h44, 32'h33}};
        vecs[2] = '{idx: 6'd0,  way: 1'd1, off: 2'd3,
                    beat: {32'h4, 32'h3, 32'h2, 32'h1},     exp: {32'h4, 32'h3, 32'h2, 32'h1} };
        vecs[3] = '{idx: 6'd10, way: 1'd0, off: 2'd1,
                    beat: {32'h8, 32'h7, 32'h6, 32'h5},     exp: {32'h7, 32'h6, 32'h5, 32'h8}};
        // vecs[2]: offset 3 gets beat0=1, then 0->2, 1->3, 2->4.
        vecs[2].exp = {32'h4, 32'h3, 32'h1, 32'h2};
        vecs[2].exp[3] = 32'h1; vecs[2].exp[0] = 32'h2; vecs[2].exp[1] = 32'h3; vecs[2].exp[2] = 32'h4;

        for (int v = 0; v < 4; v++) begin
            fill_line(int'(vecs[v].idx), int'(vecs[v].way), int'(vecs[v].off), vecs[v].beat, -1, 0, 0);
            for (int o = 0; o < WPL; o++) begin
                rd_en = 1; rd_index = vecs[v].idx; rd_offset = 2'(o);
                tick();
                rd_en = 0;
                chk($sformatf("vec%0d_valid", v), 32'(rd_valid), 32'd1);
                chk($sformatf("vec%0d_off%0d", v, o), lane(int'(vecs[v].way)), vecs[v].exp[o]);
            end
            tick();
            chk($sformatf("vec%0d_valid_drop", v), 32'(rd_valid), 32'd0);
            chk($sformatf("vec%0d_hold", v), lane(int'(vecs[v].way)), vecs[v].exp[WPL-1]);
        end

        // Stall three cycles mid-refill with a spurious fill_start aimed at set 5 way 1.
        for (int k = 0; k < WPL; k++) b[k] = 32'h5500_0000 + k;
        fill_line(4, 0, 1, b, 2, 3, 0);
        for (int o = 0; o < WPL; o++) read_chk(4, o);
        for (int o = 0; o < WPL; o++) read_chk(5, o);

        // Reset mid-refill: two beats land, the rest of the line keeps its old data.
        for (int k = 0; k < WPL; k++) b[k] = 32'h1111_0000 + k;
        fill_line(7, 0, 0, b, -1, 0, 0);
        fill_start = 1; fill_index = 7; fill_way = 0; fill_offset = 0;
        tick();
        fill_start = 0;
        for (int k = 0; k < 2; k++) begin
            fill_valid = 1; fill_data = 32'hBBBB_0000 + k;
            tick();
            m_mem[0][7][k] = 32'hBBBB_0000 + k;
        end
        rst = 1; fill_data = 32'hBBBB_0002;
        tick();
        chk("abort_busy", 32'(fill_busy), 32'd0);
        chk("abort_done", 32'(fill_done), 32'd0);
        chk("abort_ready", 32'(fill_ready), 32'd0);
        rst = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("abort_no_done", 32'(fill_done), 32'd0);
            chk("abort_idle", 32'(fill_busy), 32'd0);
        end
        fill_valid = 0;
        for (int o = 0; o < WPL; o++) read_chk(7, o);

        // Read and write of the same word in one cycle.
        for (int k = 0; k < WPL; k++) b[k] = 32'h0000_0100 + k;
        b[3] = 32'hAAAA_AAAA;
        fill_line(10, 1, 0, b, -1, 0, 0);
        fill_start = 1; fill_index = 10; fill_way = 1; fill_offset = 3;
        tick();
        fill_start = 0;
        fill_valid = 1; fill_data = 32'hCAFE_BABE;
        rd_en = 1; rd_index = 10; rd_offset = 3;
        tick();
        rd_en = 0;
        chk("coll_valid", 32'(rd_valid), 32'd1);
`ifdef ICACHE_DA_WR_FWD_EN
        chk("coll_way1", lane(1), 32'hCAFE_BABE);
`else
        chk("coll_way1", lane(1), 32'hAAAA_AAAA);
`endif
        chk("coll_way0", lane(0), m_mem[0][10][3]);
        m_mem[1][10][3] = 32'hCAFE_BABE;
        for (int k = 0; k < 3; k++) begin
            fill_data = 32'h0000_0200 + k;
            tick();
            m_mem[1][10][k] = 32'h0000_0200 + k;
        end
        fill_valid = 0;
        chk("coll_done", 32'(fill_done), 32'd1);
        tick();
        for (int o = 0; o < WPL; o++) read_chk(10, o);

        // Back-to-back refills: second fill_start in the fill_done cycle.
        for (int k = 0; k < WPL; k++) begin
            b[k]  = 32'h3000_0000 + k;
            b2[k] = 32'h3100_0000 + k;
        end
        fill_line(30, 0, 1, b, -1, 0, 1);
        fill_line(30, 1, 2, b2, -1, 0, 0);
        for (int o = 0; o < WPL; o++) read_chk(30, o);

        // Randomized traffic on a small group of sets to provoke collisions.
        idle_inputs();
        a_act = 0; e_done = 0; a_idx = 0; a_way = 0; a_ptr = 0; a_cnt = 0;
        for (int w = 0; w < NW; w++) begin e_lane[w] = '0; e_known[w] = 0; end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            fill_start  = ($urandom_range(0, 4) == 0);
            fill_index  = 6'(40 + $urandom_range(0, 3));
            fill_way    = 1'($urandom_range(0, 1));
            fill_offset = 2'($urandom_range(0, 3));
            fill_valid  = ($urandom_range(0, 9) < 7);
            fill_data   = $urandom;
            rd_en       = ($urandom_range(0, 1) == 1);
            rd_index    = 6'(40 + $urandom_range(0, 3));
            rd_offset   = 2'($urandom_range(0, 3));

            wr = a_act && fill_valid;
            if (rd_en) begin
                for (int w = 0; w < NW; w++) begin
                    e_lane[w]  = m_mem[w][rd_index][rd_offset];
                    e_known[w] = m_ok[w][rd_index][rd_offset];
`ifdef ICACHE_DA_WR_FWD_EN
                    if (wr && w == a_way && int'(rd_index) == a_idx && int'(rd_offset) == a_ptr) begin
                        e_lane[w]  = fill_data;
                        e_known[w] = 1;
                    end
`endif
                end
            end
            e_done = 0;
            if (a_act) begin
                if (wr) begin
                    m_mem[a_way][a_idx][a_ptr] = fill_data;
                    m_ok[a_way][a_idx][a_ptr]  = 1;
                    a_ptr = (a_ptr + 1) % WPL;
                    a_cnt++;
                    if (a_cnt == WPL) begin a_act = 0; e_done = 1; end
                end
            end else if (fill_start) begin
                a_act = 1; a_idx = int'(fill_index); a_way = int'(fill_way);
                a_ptr = int'(fill_offset); a_cnt = 0;
            end
            tick();
            chk("rnd_rd_valid", 32'(rd_valid), 32'(rd_en));
            for (int w = 0; w < NW; w++)
                if (e_known[w]) chk($sformatf("rnd_lane%0d", w), lane(w), e_lane[w]);
            chk("rnd_done", 32'(fill_done), 32'(e_done));
            chk("rnd_busy", 32'(fill_busy), 32'(a_act));
            chk("rnd_ready", 32'(fill_ready), 32'(a_act));
        end
        idle_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
